// File: rtl/uc_alu_mc_pkg.sv
// Shared codes for the registered ALU control decoder: select codes, aluop
// classes, R-type funct values and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] SEL_ADD = 4'b0000;
  localparam logic [3:0] SEL_SUB = 4'b0001;
  localparam logic [3:0] SEL_MUL = 4'b0010;
  localparam logic [3:0] SEL_DIV = 4'b0011;
  localparam logic [3:0] SEL_AND = 4'b0100;
  localparam logic [3:0] SEL_OR  = 4'b0101;
  localparam logic [3:0] SEL_XOR = 4'b0110;
  localparam logic [3:0] SEL_NOT = 4'b0111;
  localparam logic [3:0] SEL_SLT = 4'b1000;

  localparam logic [2:0] ALUOP_MEM  = 3'b000;
  localparam logic [2:0] ALUOP_BEQ  = 3'b001;
  localparam logic [2:0] ALUOP_R    = 3'b010;
  localparam logic [2:0] ALUOP_ANDI = 3'b011;
  localparam logic [2:0] ALUOP_ORI  = 3'b100;
  localparam logic [2:0] ALUOP_SLTI = 3'b101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100001;
  localparam logic [5:0] F_MUL = 6'b100010;
  localparam logic [5:0] F_DIV = 6'b100011;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOT = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/uc_alu_mc_if.sv
// Handshake bundle between main control (master) and the ALU control
// sequencer (slave); the select/status signals flow back to the master.
interface uc_alu_mc_if #(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int SEL_W   = 4
) ();

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [ALUOP_W-1:0] aluop;
  logic [FUNCT_W-1:0] funct;
  logic [SEL_W-1:0]   sel;
  logic               illegal;
  logic               alu_start;
  logic               stall;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output flush, in_valid, aluop, funct, out_ready,
    input  in_ready, sel, illegal, alu_start, stall, out_valid
  );

  modport slave (
    input  flush, in_valid, aluop, funct, out_ready,
    output in_ready, sel, illegal, alu_start, stall, out_valid
  );

endinterface

// File: rtl/uc_alu_mc_dec.sv
// Combinational aluop/funct decode into ALU select, illegal flag and the
// multi-cycle class (mul/div); zero latency, no state.
module uc_alu_mc_dec
  import alu_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int FUNCT_W = 6,
  parameter int SEL_W   = 4
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [SEL_W-1:0]   sel,
  output logic               illegal,
  output logic               is_mul,
  output logic               is_div
);

  logic [SEL_W-1:0] r_sel;
  logic             r_illegal;

  always_comb begin
    r_sel     = SEL_W'(SEL_ADD);
    r_illegal = 1'b0;
    case (funct)
      FUNCT_W'(F_ADD): r_sel = SEL_W'(SEL_ADD);
      FUNCT_W'(F_SUB): r_sel = SEL_W'(SEL_SUB);
      FUNCT_W'(F_MUL): r_sel = SEL_W'(SEL_MUL);
      FUNCT_W'(F_DIV): r_sel = SEL_W'(SEL_DIV);
      FUNCT_W'(F_AND): r_sel = SEL_W'(SEL_AND);
      FUNCT_W'(F_OR):  r_sel = SEL_W'(SEL_OR);
      FUNCT_W'(F_XOR): r_sel = SEL_W'(SEL_XOR);
      FUNCT_W'(F_NOT): r_sel = SEL_W'(SEL_NOT);
      FUNCT_W'(F_SLT): r_sel = SEL_W'(SEL_SLT);
      default:         r_illegal = 1'b1;
    endcase
  end

  always_comb begin
    sel     = SEL_W'(SEL_ADD);
    illegal = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (aluop)
      ALUOP_W'(ALUOP_MEM):  sel = SEL_W'(SEL_ADD);
      ALUOP_W'(ALUOP_BEQ):  sel = SEL_W'(SEL_SUB);
      ALUOP_W'(ALUOP_ANDI): sel = SEL_W'(SEL_AND);
      ALUOP_W'(ALUOP_ORI):  sel = SEL_W'(SEL_OR);
      ALUOP_W'(ALUOP_SLTI): sel = SEL_W'(SEL_SLT);
      ALUOP_W'(ALUOP_R): begin
        sel     = r_sel;
        illegal = r_illegal;
        is_mul  = (funct == FUNCT_W'(F_MUL));
        is_div  = (funct == FUNCT_W'(F_DIV));
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_alu_mc.sv
// Registered ALU control sequencer: single-cycle ops reach HOLD one cycle after
// accept, mul/div after N+1; in_ready drops while executing or holding unread.
module uc_alu_mc
  import alu_pkg::*;
#(
  parameter int ALUOP_W    = 3,
  parameter int FUNCT_W    = 6,
  parameter int SEL_W      = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  uc_alu_mc_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             illegal_q, illegal_d;
  logic             alu_start_q, alu_start_d;
  logic             stall_q, stall_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_illegal;
  logic             dec_is_mul;
  logic             dec_is_div;
  logic             in_ready;
  logic             accept;

  uc_alu_mc_dec #(
    .ALUOP_W (ALUOP_W),
    .FUNCT_W (FUNCT_W),
    .SEL_W   (SEL_W)
  ) u_dec (
    .aluop   (bus.aluop),
    .funct   (bus.funct),
    .sel     (dec_sel),
    .illegal (dec_illegal),
    .is_mul  (dec_is_mul),
    .is_div  (dec_is_div)
  );

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
  // flush wins over a same-cycle handshake: the op stays with upstream
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    illegal_d   = illegal_q;
    alu_start_d = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HOLD: begin
          if (accept) begin
            sel_d     = dec_sel;
            illegal_d = dec_illegal;
            if (dec_is_mul) begin
              state_d     = ST_EXEC;
              cnt_d       = CNT_W'(MUL_CYCLES - 1);
              alu_start_d = 1'b1;
            end else if (dec_is_div) begin
              state_d     = ST_EXEC;
              cnt_d       = CNT_W'(DIV_CYCLES - 1);
              alu_start_d = 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = '0;
            end
          end else if ((state_q == ST_HOLD) && bus.out_ready) begin
            state_d = ST_IDLE;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    stall_d     = (state_d == ST_EXEC);
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      illegal_q   <= 1'b0;
      alu_start_q <= 1'b0;
      stall_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      illegal_q   <= illegal_d;
      alu_start_q <= alu_start_d;
      stall_q     <= stall_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.sel       = sel_q;
  assign bus.illegal   = illegal_q;
  assign bus.alu_start = alu_start_q;
  assign bus.stall     = stall_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_uc_alu_mc.sv
// Directed bench for uc_alu_mc: decode, mul/div windows, back-to-back, flush
// and asynchronous reset, checked against hand-computed values.
`define CHK(tag, obs, exp) begin \
  checks++; \
  assert ((obs) === (exp)) else begin \
    errors++; \
    $error("FAIL %s obs=%0h exp=%0h", tag, (obs), (exp)); \
  end \
end

module tb_uc_alu_mc;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic done;

  uc_alu_mc_if #(.ALUOP_W(3), .FUNCT_W(6), .SEL_W(4)) u_if ();

  uc_alu_mc #(
    .ALUOP_W    (3),
    .FUNCT_W    (6),
    .SEL_W      (4),
    .MUL_CYCLES (4),
    .DIV_CYCLES (8),
    .CNT_W      (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    done = 1'b0;
    #20000;
    if (!done) begin
      errors++;
      $error("FAIL timeout: directed sequence did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
    u_if.in_valid = v;
    u_if.aluop    = op;
    u_if.funct    = fn;
  endtask

  task automatic chk_rst(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL reset %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n          = 1'b0;
    u_if.flush     = 1'b0;
    u_if.out_ready = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);

    // reset state, including combinational in_ready
    #2;
    chk_rst("rst_sel",       u_if.sel,                4'h0);
    chk_rst("rst_illegal",   {3'b000, u_if.illegal},   4'h0);
    chk_rst("rst_alu_start", {3'b000, u_if.alu_start}, 4'h0);
    chk_rst("rst_stall",     {3'b000, u_if.stall},     4'h0);
    chk_rst("rst_out_valid", {3'b000, u_if.out_valid}, 4'h0);
    chk_rst("rst_in_ready",  {3'b000, u_if.in_ready},  4'h1);
    #10 rst_n = 1'b1;
    tick();

    // R-type add: one-cycle latency, held while out_ready is low
    drive(1'b1, 3'b010, 6'b100000);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    `CHK("add_sel",       u_if.sel,       4'h0)
    `CHK("add_out_valid", u_if.out_valid, 1'b1)
    `CHK("add_stall",     u_if.stall,     1'b0)
    `CHK("add_in_ready",  u_if.in_ready,  1'b0)
    tick();
    `CHK("add_hold_valid", u_if.out_valid, 1'b1)
    u_if.out_ready = 1'b1;
    tick();
    `CHK("add_drain_valid", u_if.out_valid, 1'b0)

    // mul: 4-cycle window, next op waits with in_valid high
    drive(1'b1, 3'b010, 6'b100010);
    tick();
    drive(1'b1, 3'b000, 6'b000000);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) tick();
      `CHK("mul_alu_start", u_if.alu_start, (i == 1))
      `CHK("mul_stall",     u_if.stall,     (i <= 4))
      `CHK("mul_out_valid", u_if.out_valid, (i == 5))
      `CHK("mul_sel",       u_if.sel,       4'h2)
    end
    `CHK("mul_hold_in_ready", u_if.in_ready, 1'b1)

    // back-to-back: add then andi straight out of HOLD
    tick();
    `CHK("b2b_add_sel",   u_if.sel,       4'h0)
    `CHK("b2b_add_valid", u_if.out_valid, 1'b1)
    drive(1'b1, 3'b011, 6'b000000);
    tick();
    `CHK("b2b_and_sel",   u_if.sel,       4'h4)
    `CHK("b2b_and_valid", u_if.out_valid, 1'b1)

    // illegal funct, then illegal aluop, then immediate forms
    drive(1'b1, 3'b010, 6'b111111);
    tick();
    `CHK("ill_f_sel",     u_if.sel,       4'h0)
    `CHK("ill_f_illegal", u_if.illegal,   1'b1)
    `CHK("ill_f_stall",   u_if.stall,     1'b0)
    `CHK("ill_f_start",   u_if.alu_start, 1'b0)
    `CHK("ill_f_valid",   u_if.out_valid, 1'b1)
    drive(1'b1, 3'b111, 6'b100010);
    tick();
    `CHK("ill_op_sel",     u_if.sel,       4'h0)
    `CHK("ill_op_illegal", u_if.illegal,   1'b1)
    `CHK("ill_op_stall",   u_if.stall,     1'b0)
    `CHK("ill_op_start",   u_if.alu_start, 1'b0)
    drive(1'b1, 3'b101, 6'b000000);
    tick();
    `CHK("slti_sel",     u_if.sel,     4'h8)
    `CHK("slti_illegal", u_if.illegal, 1'b0)
    drive(1'b1, 3'b100, 6'b000000);
    tick();
    `CHK("ori_sel", u_if.sel, 4'h5)
    drive(1'b1, 3'b010, 6'b100110);
    tick();
    `CHK("xor_sel", u_if.sel, 4'h6)
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    `CHK("idle_valid", u_if.out_valid, 1'b0)

    // div flushed in its 3rd execute cycle
    drive(1'b1, 3'b010, 6'b100011);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    `CHK("div_sel",   u_if.sel,       4'h3)
    `CHK("div_start", u_if.alu_start, 1'b1)
    `CHK("div_stall", u_if.stall,     1'b1)
    tick();
    tick();
    `CHK("div_c3_stall",    u_if.stall,    1'b1)
    `CHK("div_c3_in_ready", u_if.in_ready, 1'b0)
    u_if.flush = 1'b1;
    drive(1'b1, 3'b000, 6'b000000);
    tick();
    u_if.flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    `CHK("flush_stall",    u_if.stall,     1'b0)
    `CHK("flush_valid",    u_if.out_valid, 1'b0)
    `CHK("flush_start",    u_if.alu_start, 1'b0)
    `CHK("flush_sel_hold", u_if.sel,       4'h3)
    `CHK("flush_in_ready", u_if.in_ready,  1'b1)
    for (int i = 0; i < 6; i++) begin
      tick();
      `CHK("flush_no_valid", u_if.out_valid, 1'b0)
    end
    drive(1'b1, 3'b001, 6'b000000);
    tick();
    `CHK("post_flush_sel",   u_if.sel,       4'h1)
    `CHK("post_flush_valid", u_if.out_valid, 1'b1)

    // flush in HOLD blocks a same-cycle accept
    drive(1'b1, 3'b011, 6'b000000);
    u_if.flush = 1'b1;
    tick();
    u_if.flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);
    `CHK("flush_hold_valid", u_if.out_valid, 1'b0)
    `CHK("flush_hold_sel",   u_if.sel,       4'h1)

    // asynchronous reset in the middle of a mul
    drive(1'b1, 3'b010, 6'b100010);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    `CHK("pre_arst_stall", u_if.stall, 1'b1)
    #2 rst_n = 1'b0;
    #1;
    `CHK("arst_stall",    u_if.stall,     1'b0)
    `CHK("arst_sel",      u_if.sel,       4'h0)
    `CHK("arst_valid",    u_if.out_valid, 1'b0)
    `CHK("arst_start",    u_if.alu_start, 1'b0)
    `CHK("arst_in_ready", u_if.in_ready,  1'b1)
    tick();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      `CHK("rel_start",    u_if.alu_start, 1'b0)
      `CHK("rel_stall",    u_if.stall,     1'b0)
      `CHK("rel_in_ready", u_if.in_ready,  1'b1)
    end

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
